// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC predictor: Y86-64 icodes,
// the RAS checkpoint width helper and the next-PC select encoding.
package pc_pkg;

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] ICODE_CALL = 4'h8;
    localparam logic [3:0] ICODE_RET  = 4'h9;

    // Checkpoint is {ptr, count}: ptr is clog2(depth) bits and count needs
    // one extra bit so that it can hold the value "depth".
    function automatic int ckpt_w(input int depth);
        return 2 * $clog2(depth) + 1;
    endfunction

    // Next-PC sources, listed from highest to lowest priority.
    typedef enum logic [3:0] {
        SEL_RST,
        SEL_MISPRED,
        SEL_RETFIX,
        SEL_STALL,
        SEL_HOLD,
        SEL_TAKEN,
        SEL_CALL,
        SEL_RET,
        SEL_SEQ
    } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. ptr is the next write slot, so the top
// of stack is entry ptr-1. Pushing when full overwrites the oldest entry
// and saturates count. Restore reloads {ptr,count} from a checkpoint and
// leaves the entries alone.
module ras_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1,
    localparam int CKPT_W = PTR_W + CNT_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              restore,
    input  logic [CKPT_W-1:0] restore_ckpt,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic [CKPT_W-1:0] ckpt,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;

    assign top  = mem[ptr - PTR_W'(1)];
    assign ckpt = {ptr, count};

    // Entry storage: no reset, contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push && !rst && !restore) begin
            mem[ptr] <= push_data;
        end
    end

    // Pointer, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (restore) begin
            {ptr, count} <= restore_ckpt;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (count == CNT_W'(DEPTH)) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && (count != '0)) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage PC generator for the pipelined Y86-64 core.
// Predicts jXX taken, call to valC, ret from the return-address stack,
// otherwise valP; corrects jXX mispredicts from M and ret mispredicts
// from W. Define PC_RAS_EN to build the RAS; without it a ret stalls
// the fetch PC (ret_pending) until the ret reaches W.
module pc_predict_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    localparam int               CNT_W     = $clog2(RAS_DEPTH) + 1,
    localparam int               CKPT_W    = ckpt_w(RAS_DEPTH)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              f_stall,
    input  logic              f_valid,
    input  logic [3:0]        f_icode,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] f_ras_pred,
    output logic [CKPT_W-1:0] f_ras_ckpt,
    input  logic [3:0]        m_icode,
    input  logic              m_cnd,
    input  logic [ADDR_W-1:0] m_valA,
    input  logic [CKPT_W-1:0] m_ras_ckpt,
    input  logic [3:0]        w_icode,
    input  logic [ADDR_W-1:0] w_valM,
    input  logic [ADDR_W-1:0] w_ras_pred,
    output logic              ret_pending,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_ovf
);

    pc_sel_e           sel;
    logic [ADDR_W-1:0] pc_next;
    logic              m_mispred;
    logic              w_fix;
    logic              ret_pend_q;

    assign m_mispred = (m_icode == ICODE_JXX) && !m_cnd;

`ifdef PC_RAS_EN
    logic [ADDR_W-1:0] ras_top;

    assign w_fix      = (w_icode == ICODE_RET) && (w_valM != w_ras_pred);
    assign ret_pend_q = 1'b0;

    ras_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk          (clk),
        .rst          (rst),
        .push         (sel == SEL_CALL),
        .pop          (sel == SEL_RET),
        .restore      (sel == SEL_MISPRED),
        .restore_ckpt (m_ras_ckpt),
        .push_data    (f_valP),
        .top          (ras_top),
        .ckpt         (f_ras_ckpt),
        .count        (ras_count),
        .ovf          (ras_ovf)
    );

    // An empty stack predicts fall-through; the W check repairs it later.
    assign f_ras_pred = (ras_count == '0) ? f_valP : ras_top;
`else
    logic unused_ras_ins;

    assign unused_ras_ins = ^{m_ras_ckpt, w_ras_pred};
    assign w_fix          = (w_icode == ICODE_RET);
    assign f_ras_pred     = '0;
    assign f_ras_ckpt     = '0;
    assign ras_count      = '0;
    assign ras_ovf        = 1'b0;

    // Ret waits for its real target: set on fetch, cleared when redirected.
    always_ff @(posedge clk) begin
        if (rst || sel == SEL_MISPRED || sel == SEL_RETFIX) begin
            ret_pend_q <= 1'b0;
        end else if (sel == SEL_RET) begin
            ret_pend_q <= 1'b1;
        end
    end
`endif

    assign ret_pending = ret_pend_q;

    // Pick the next-PC source in priority order; corrections beat stalls.
    always_comb begin
        sel = SEL_SEQ;
        if (rst) begin
            sel = SEL_RST;
        end else if (m_mispred) begin
            sel = SEL_MISPRED;
        end else if (w_fix) begin
            sel = SEL_RETFIX;
        end else if (f_stall) begin
            sel = SEL_STALL;
        end else if (!f_valid || f_icode == ICODE_HALT || ret_pend_q) begin
            sel = SEL_HOLD;
        end else if (f_icode == ICODE_JXX) begin
            sel = SEL_TAKEN;
        end else if (f_icode == ICODE_CALL) begin
            sel = SEL_CALL;
        end else if (f_icode == ICODE_RET) begin
            sel = SEL_RET;
        end
    end

    // Next-PC mux.
    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_RST:     pc_next = RESET_PC;
            SEL_MISPRED: pc_next = m_valA;
            SEL_RETFIX:  pc_next = w_valM;
            SEL_TAKEN:   pc_next = f_valC;
            SEL_CALL:    pc_next = f_valC;
`ifdef PC_RAS_EN
            SEL_RET:     pc_next = f_ras_pred;
`else
            SEL_RET:     pc_next = pc;
`endif
            SEL_SEQ:     pc_next = f_valP;
            default:     pc_next = pc;
        endcase
    end

    // Architectural fetch PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit (RAS_DEPTH=4, RESET_PC=0x100).
// Covers both builds; the RAS-specific section follows PC_RAS_EN.
module tb_pc_predict_unit;

    localparam int ADDR_W = 64;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;
    localparam int CKPT_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              f_stall;
    logic              f_valid;
    logic [3:0]        f_icode;
    logic [ADDR_W-1:0] f_valC;
    logic [ADDR_W-1:0] f_valP;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] f_ras_pred;
    logic [CKPT_W-1:0] f_ras_ckpt;
    logic [3:0]        m_icode;
    logic              m_cnd;
    logic [ADDR_W-1:0] m_valA;
    logic [CKPT_W-1:0] m_ras_ckpt;
    logic [3:0]        w_icode;
    logic [ADDR_W-1:0] w_valM;
    logic [ADDR_W-1:0] w_ras_pred;
    logic              ret_pending;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_ovf;

    int checks = 0;
    int errors = 0;

    pc_predict_unit #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (DEPTH),
        .RESET_PC  (64'h100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .f_stall     (f_stall),
        .f_valid     (f_valid),
        .f_icode     (f_icode),
        .f_valC      (f_valC),
        .f_valP      (f_valP),
        .pc          (pc),
        .f_ras_pred  (f_ras_pred),
        .f_ras_ckpt  (f_ras_ckpt),
        .m_icode     (m_icode),
        .m_cnd       (m_cnd),
        .m_valA      (m_valA),
        .m_ras_ckpt  (m_ras_ckpt),
        .w_icode     (w_icode),
        .w_valM      (w_valM),
        .w_ras_pred  (w_ras_pred),
        .ret_pending (ret_pending),
        .ras_count   (ras_count),
        .ras_ovf     (ras_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
        f_valid = 1'b1;
        f_icode = ic;
        f_valC  = vc;
        f_valP  = vp;
    endtask

    initial begin
        rst = 1'b1; f_stall = 1'b0; f_valid = 1'b0; f_icode = 4'h0;
        f_valC = '0; f_valP = '0; m_icode = 4'h0; m_cnd = 1'b0; m_valA = '0;
        m_ras_ckpt = '0; w_icode = 4'h0; w_valM = '0; w_ras_pred = '0;

        tick();
        chk("reset_pc", pc, 64'h100);
        chk("reset_count", 64'(ras_count), 64'd0);
        chk("reset_ovf", 64'(ras_ovf), 64'd0);
        chk("reset_retpend", 64'(ret_pending), 64'd0);
        rst = 1'b0;

        fetch(4'h3, 64'h0, 64'h10A); tick(); chk("seq1", pc, 64'h10A);
        fetch(4'h3, 64'h0, 64'h114); tick(); chk("seq2", pc, 64'h114);
        fetch(4'h3, 64'h0, 64'h11E); tick(); chk("seq3", pc, 64'h11E);

        f_valid = 1'b0; tick(); chk("invalid_hold", pc, 64'h11E);
        fetch(4'h0, 64'h0, 64'h11F); tick(); chk("halt_hold", pc, 64'h11E);

        // jXX predicted taken, wrong-path call, then mispredict from M
        fetch(4'h7, 64'h80, 64'h128); tick(); chk("jxx_taken", pc, 64'h80);
        fetch(4'h8, 64'h200, 64'h8A); tick(); chk("wp_call", pc, 64'h200);
`ifdef PC_RAS_EN
        chk("wp_call_count", 64'(ras_count), 64'd1);
`endif
        fetch(4'h3, 64'h0, 64'h20A);
        m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h128; m_ras_ckpt = 5'd0;
        tick();
        chk("mispred_pc", pc, 64'h128);
        chk("mispred_count", 64'(ras_count), 64'd0);

        // Mispredict in M, RET mismatch in W and a stall in the same cycle
        f_stall = 1'b1; m_valA = 64'h300;
        w_icode = 4'h9; w_valM = 64'h500; w_ras_pred = 64'h999;
        tick(); chk("prio_m_over_w", pc, 64'h300);
        m_icode = 4'h0; w_icode = 4'h0;

        fetch(4'h3, 64'h0, 64'h999); tick(); chk("stall_hold", pc, 64'h300);
        f_stall = 1'b0;

        // jXX resolved taken in M is not a correction
        m_icode = 4'h7; m_cnd = 1'b1; m_valA = 64'h555;
        fetch(4'h3, 64'h0, 64'h30A); tick(); chk("jxx_cnd_ok", pc, 64'h30A);
        m_icode = 4'h0; m_cnd = 1'b0;

`ifdef PC_RAS_EN
        fetch(4'h8, 64'h400, 64'h20); tick();
        chk("call_pc", pc, 64'h400);
        chk("call_count", 64'(ras_count), 64'd1);
        chk("ckpt_after_call", 64'(f_ras_ckpt), 64'h09);

        fetch(4'h7, 64'h480, 64'h40A); tick(); chk("jxx2", pc, 64'h480);
        fetch(4'h8, 64'h900, 64'h48A); tick(); chk("wp_call2_count", 64'(ras_count), 64'd2);
        fetch(4'h3, 64'h0, 64'h904);
        m_icode = 4'h7; m_valA = 64'h40A; m_ras_ckpt = 5'h09;
        tick();
        chk("restore_pc", pc, 64'h40A);
        chk("restore_count", 64'(ras_count), 64'd1);
        m_icode = 4'h0;

        fetch(4'h9, 64'h0, 64'h414);
        #1 chk("ras_pred", f_ras_pred, 64'h20);
        tick();
        chk("ret_pc", pc, 64'h20);
        chk("ret_count", 64'(ras_count), 64'd0);

        w_icode = 4'h9; w_valM = 64'h20; w_ras_pred = 64'h20;
        fetch(4'h3, 64'h0, 64'h2A); tick(); chk("ret_ok_no_fix", pc, 64'h2A);
        w_icode = 4'h0;

        for (int i = 0; i < 5; i++) begin
            fetch(4'h8, 64'h1000 + 64'(i) * 64'h100, 64'h610 + 64'(i) * 64'h10);
            tick();
            chk("nest_call_pc", pc, 64'h1000 + 64'(i) * 64'h100);
        end
        chk("ovf_flag", 64'(ras_ovf), 64'd1);
        chk("ovf_count", 64'(ras_count), 64'd4);
        chk("ovf_ckpt", 64'(f_ras_ckpt), 64'h0C);

        for (int k = 0; k < 4; k++) begin
            fetch(4'h9, 64'h0, 64'h777);
            tick();
            chk("nest_ret_pc", pc, 64'h610 + 64'(4 - k) * 64'h10);
        end
        chk("drained_count", 64'(ras_count), 64'd0);
        tick(); chk("empty_ret_pc", pc, 64'h777);
        chk("empty_ret_count", 64'(ras_count), 64'd0);
        f_valid = 1'b0;
        w_icode = 4'h9; w_valM = 64'h610; w_ras_pred = 64'h777;
        tick(); chk("w_fix_pc", pc, 64'h610);
        w_icode = 4'h0;
        chk("ovf_sticky", 64'(ras_ovf), 64'd1);

        fetch(4'h8, 64'h2000, 64'h61A); tick(); chk("pre_rst_count", 64'(ras_count), 64'd1);
        rst = 1'b1; tick();
        chk("midrst_pc", pc, 64'h100);
        chk("midrst_count", 64'(ras_count), 64'd0);
        chk("midrst_ovf", 64'(ras_ovf), 64'd0);
        rst = 1'b0;
`else
        fetch(4'h8, 64'h400, 64'h20);
        #1 chk("noras_pred", f_ras_pred, 64'h0);
        chk("noras_ckpt", 64'(f_ras_ckpt), 64'h0);
        tick();
        chk("call_pc", pc, 64'h400);
        chk("call_count", 64'(ras_count), 64'd0);

        fetch(4'h9, 64'h0, 64'h40A); tick();
        chk("ret_hold_pc", pc, 64'h400);
        chk("ret_pending_set", 64'(ret_pending), 64'd1);
        fetch(4'h3, 64'h0, 64'h40A); tick();
        chk("pending_hold_pc", pc, 64'h400);
        chk("pending_kept", 64'(ret_pending), 64'd1);

        w_icode = 4'h9; w_valM = 64'h58; w_ras_pred = 64'h58;
        tick();
        chk("w_ret_pc", pc, 64'h58);
        chk("ret_pending_clr", 64'(ret_pending), 64'd0);
        w_icode = 4'h0;
        chk("noras_ovf", 64'(ras_ovf), 64'd0);

        fetch(4'h8, 64'h2000, 64'h62); tick(); chk("call2_pc", pc, 64'h2000);
        rst = 1'b1; tick();
        chk("midrst_pc", pc, 64'h100);
        chk("midrst_count", 64'(ras_count), 64'd0);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
